// File: rtl/ocm_dual_port_arbiter.sv
// rtl/ocm_dual_port_arbiter.sv - round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
// Optional conflict counter enabled by defining OCM_ARB_STATS_EN.
module ocm_dual_port_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
`ifdef OCM_ARB_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
`ifdef OCM_ARB_STATS_EN
  ,
  input  logic              stats_clear,
  output logic [CNT_W-1:0]  conflict_count
`endif
);

  logic              req0, req1;
  logic              grant0, grant1;
  logic              accept;
  logic              sel_write;
  logic              last_grant;
  logic              tag_valid;
  logic              tag_owner;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // last_grant == 1 means m1 won the previous access, so m0 wins a tie.
  assign grant0 = req0 & (~req1 | last_grant);
  assign grant1 = req1 & (~req0 | ~last_grant);
  assign accept = grant0 | grant1;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  assign sel_write = grant0 ? m0_write : m1_write;

  always_comb begin
    ram_address    = addr_q;
    ram_byteenable = be_q;
    ram_writedata  = wdata_q;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    if (!reset && accept) begin
      ram_chipselect = 1'b1;
      ram_write      = sel_write;
      if (grant0) begin
        ram_address    = m0_address;
        ram_byteenable = m0_byteenable;
        ram_writedata  = m0_writedata;
      end else begin
        ram_address    = m1_address;
        ram_byteenable = m1_byteenable;
        ram_writedata  = m1_writedata;
      end
    end
  end

  assign ram_clken = ~reset;

  // Hold the last driven RAM bus so idle cycles do not toggle the address/data lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= ram_address;
      be_q    <= ram_byteenable;
      wdata_q <= ram_writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      tag_valid  <= 1'b0;
      tag_owner  <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant1;
      end
      tag_valid <= accept & ~sel_write;
      tag_owner <= grant1;
    end
  end

  assign m0_readdatavalid = tag_valid & ~tag_owner;
  assign m1_readdatavalid = tag_valid & tag_owner;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

`ifdef OCM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_count <= '0;
    end else if (stats_clear) begin
      conflict_count <= '0;
    end else if (req0 && req1 && !(&conflict_count)) begin
      conflict_count <= conflict_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ocm_dual_port_arbiter.sv
// tb/tb_ocm_dual_port_arbiter.sv - randomized and directed bench for ocm_dual_port_arbiter against a transaction-level model.
// Covers the conflict counter too when OCM_ARB_STATS_EN is defined.
module tb_ocm_dual_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [1:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;
`ifdef OCM_ARB_STATS_EN
  logic        stats_clear;
  logic [15:0] conflict_count;
  int          m_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          m_last;
  logic [31:0] m_mem [4];
  bit          m_pv;
  int          m_po;
  logic [31:0] m_pd;

  // RAM: registered address, unregistered output
  logic [31:0] ram_mem [4];
  logic [1:0]  ram_raddr;

  always #5 clk = ~clk;

  ocm_dual_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
`ifdef OCM_ARB_STATS_EN
    , .stats_clear(stats_clear), .conflict_count(conflict_count)
`endif
  );

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      ram_raddr <= ram_address;
    end
  end
  assign ram_readdata = ram_mem[ram_raddr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: check at negedge against the model, advance model at posedge.
  task automatic cycle();
    bit r0, r1, wr, live;
    int win;
    logic [1:0]  a;
    logic [3:0]  be;
    logic [31:0] wd;
    @(negedge clk);
    r0 = m0_read || m0_write;
    r1 = m1_read || m1_write;
    if (reset) begin
      m_pv = 0;
`ifdef OCM_ARB_STATS_EN
      m_cnt = 0;
`endif
    end
    if (r0 && r1) win = 1 - m_last;
    else if (r0)  win = 0;
    else if (r1)  win = 1;
    else          win = -1;
    live = (win >= 0) && !reset;
    wr = (win == 0) ? m0_write : (win == 1) ? m1_write : 1'b0;
    a  = (win == 0) ? m0_address : m1_address;
    be = (win == 0) ? m0_byteenable : m1_byteenable;
    wd = (win == 0) ? m0_writedata : m1_writedata;

    check_eq("m0_wait", 32'(m0_waitrequest), 32'(r0 && win != 0));
    check_eq("m1_wait", 32'(m1_waitrequest), 32'(r1 && win != 1));
    check_eq("ram_cs", 32'(ram_chipselect), 32'(live));
    check_eq("ram_wr", 32'(ram_write), 32'(live && wr));
    check_eq("ram_clken", 32'(ram_clken), 32'(!reset));
    if (live) begin
      check_eq("ram_addr", 32'(ram_address), 32'(a));
      if (wr) begin
        check_eq("ram_be", 32'(ram_byteenable), 32'(be));
        check_eq("ram_wdata", ram_writedata, wd);
      end
    end
    if (reset) check_eq("ram_addr_rst", 32'(ram_address), 32'd0);
    check_eq("m0_rdv", 32'(m0_readdatavalid), 32'(m_pv && m_po == 0));
    check_eq("m1_rdv", 32'(m1_readdatavalid), 32'(m_pv && m_po == 1));
    if (m_pv) check_eq("rdata", (m_po == 0) ? m0_readdata : m1_readdata, m_pd);
`ifdef OCM_ARB_STATS_EN
    check_eq("conflicts", 32'(conflict_count), 32'(m_cnt));
`endif

    @(posedge clk);
    if (reset) begin
      m_pv = 0;
      m_last = 1;
    end else begin
`ifdef OCM_ARB_STATS_EN
      if (stats_clear) m_cnt = 0;
      else if (r0 && r1 && m_cnt < 65535) m_cnt++;
`endif
      m_pv = 0;
      if (win >= 0) begin
        m_last = win;
        if (wr) m_mem[a] = merge(m_mem[a], wd, be);
        else begin
          m_pv = 1;
          m_po = win;
          m_pd = m_mem[a];
        end
      end
    end
    #1;
  endtask

  task automatic set_m0(input bit rd, input bit wr, input logic [1:0] a, input logic [3:0] be, input logic [31:0] wd);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
  endtask

  task automatic set_m1(input bit rd, input bit wr, input logic [1:0] a, input logic [3:0] be, input logic [31:0] wd);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
  endtask

  initial begin
    m_last = 1;
    m_pv = 0;
    m_po = 0;
    m_pd = '0;
    for (int i = 0; i < 4; i++) begin
      m_mem[i] = $urandom;
      ram_mem[i] = m_mem[i];
    end
    ram_raddr = '0;
    reset = 1'b1;
`ifdef OCM_ARB_STATS_EN
    stats_clear = 1'b0;
    m_cnt = 0;
`endif
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    cycle();
    check_eq("rst_cs", 32'(ram_chipselect), 32'd0);
    cycle();
    reset = 1'b0;

    // Single write by m0, then m1 reads it back
    set_m0(0, 1, 2'd2, 4'hF, 32'hDEADBEEF);
    cycle();
    set_m0(0, 0, 0, 0, 0);
    set_m1(1, 0, 2'd2, 4'hF, 0);
    cycle();
    check_eq("m1_rdv_dir", 32'(m1_readdatavalid), 32'd1);
    check_eq("m1_rdata_dir", m1_readdata, 32'hDEADBEEF);
    set_m1(0, 0, 0, 0, 0);
    cycle();

    // Continuous dual reads from a fresh reset alternate m0,m1,...
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_m0(1, 0, 2'd0, 4'hF, 0);
    set_m1(1, 0, 2'd1, 4'hF, 0);
    for (int i = 0; i < 8; i++) cycle();
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    cycle();

    // Partial byte write
    set_m0(0, 1, 2'd3, 4'hF, 32'h11223344);
    cycle();
    set_m0(0, 1, 2'd3, 4'b0010, 32'h0000AB00);
    cycle();
    set_m0(0, 0, 0, 0, 0);
    set_m1(1, 0, 2'd3, 4'hF, 0);
    cycle();
    check_eq("pw_rdata", m1_readdata, 32'h1122AB44);
    set_m1(0, 0, 0, 0, 0);
    cycle();

    // Reset right after an accepted read, then first conflict goes to m0
    set_m0(1, 0, 2'd1, 4'hF, 0);
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    set_m0(0, 0, 0, 0, 0);
    cycle();
    set_m0(1, 0, 2'd0, 4'hF, 0);
    set_m1(1, 0, 2'd1, 4'hF, 0);
    #1;
    check_eq("post_rst_m0_wait", 32'(m0_waitrequest), 32'd0);
    check_eq("post_rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    cycle();

`ifdef OCM_ARB_STATS_EN
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check_eq("cnt5", 32'(conflict_count), 32'd5);
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    stats_clear = 1'b1;
    cycle();
    stats_clear = 1'b0;
    check_eq("cnt_clr", 32'(conflict_count), 32'd0);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      set_m0($urandom_range(0, 1), $urandom_range(0, 3) == 0, 2'($urandom), 4'($urandom), $urandom);
      set_m1($urandom_range(0, 1), $urandom_range(0, 3) == 0, 2'($urandom), 4'($urandom), $urandom);
      reset = ($urandom_range(0, 39) == 0);
`ifdef OCM_ARB_STATS_EN
      stats_clear = ($urandom_range(0, 19) == 0);
`endif
      cycle();
    end
    reset = 1'b0;
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
